// File: rtl/lsp_get_tdist_if.sv
// Scratch-memory and control bundle between a caller (master) and the
// lsp_get_tdist engine (slave).
interface lsp_get_tdist_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    // start is a one-cycle request honoured only while the engine is idle;
    // the address inputs must stay stable from start until the done pulse,
    // readIn answers readAddr one cycle later, done pulses one cycle after
    // the single writeEn cycle.
    logic              start;
    logic [ADDR_W-1:0] wegtAddr;
    logic [ADDR_W-1:0] bufAddr;
    logic [ADDR_W-1:0] rbufAddr;
    logic [ADDR_W-1:0] fgSumAddr;
    logic [ADDR_W-1:0] L_tdist;
    logic [DATA_W-1:0] readIn;
    logic [ADDR_W-1:0] readAddr;
    logic [ADDR_W-1:0] writeAddr;
    logic [DATA_W-1:0] writeOut;
    logic              writeEn;
    logic              done;

    modport master (
        output start, wegtAddr, bufAddr, rbufAddr, fgSumAddr, L_tdist, readIn,
        input  readAddr, writeAddr, writeOut, writeEn, done
    );

    modport slave (
        input  start, wegtAddr, bufAddr, rbufAddr, fgSumAddr, L_tdist, readIn,
        output readAddr, writeAddr, writeOut, writeEn, done
    );
endinterface

// File: rtl/lsp_get_tdist.sv
// G.729 Lsp_get_tdist: weighted, saturating distance over M LSP elements,
// read from scratch memory and written back as one 32-bit word.
module lsp_get_tdist #(
    parameter int M      = 10,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    lsp_get_tdist_if.slave bus,
    output logic [3:0]     dbg_state_o
);
    localparam int JW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_C1, S_C2, S_WRITE, S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [JW-1:0]      j_q, j_d;
    logic signed [15:0] buf_q, buf_d, rbuf_q, rbuf_d, fg_q, fg_d, wegt_q, wegt_d;
    logic signed [15:0] t_q, t_d;
    logic signed [31:0] acc_q, acc_d;

    function automatic logic signed [15:0] sub_sat(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
        logic signed [16:0] d;
        d = 17'(a) - 17'(b);
        if (d > 17'sd32767) return 16'sh7FFF;
        if (d < -17'sd32768) return 16'sh8000;
        return d[15:0];
    endfunction

    // 0x8000 * 0x8000 is the only product whose doubling overflows.
    function automatic logic signed [31:0] l_mult(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
        logic signed [31:0] p;
        p = 32'(a) * 32'(b);
        if (p == 32'sh4000_0000) return 32'sh7FFF_FFFF;
        return p <<< 1;
    endfunction

    function automatic logic signed [31:0] l_shl(input logic signed [31:0] x,
                                                 input int n);
        logic signed [39:0] w;
        w = 40'(x) <<< n;
        if (w > 40'sh00_7FFF_FFFF) return 32'sh7FFF_FFFF;
        if (w < -40'sh00_8000_0000) return 32'sh8000_0000;
        return w[31:0];
    endfunction

    function automatic logic signed [31:0] l_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
        logic signed [32:0] s;
        s = 33'(a) + 33'(b);
        if (s > 33'sh0_7FFF_FFFF) return 32'sh7FFF_FFFF;
        if (s < -33'sh0_8000_0000) return 32'sh8000_0000;
        return s[31:0];
    endfunction

    logic signed [15:0] diff, c1_t, c2_t2;
    logic signed [31:0] c1_p, c2_p, c2_acc;

    always_comb begin
        diff   = sub_sat(buf_q, rbuf_q);
        c1_p   = l_shl(l_mult(diff, fg_q), 3);
        c1_t   = c1_p[31:16];
        c2_p   = l_shl(l_mult(wegt_q, t_q), 4);
        c2_t2  = c2_p[31:16];
        c2_acc = l_add(acc_q, l_mult(c2_t2, t_q));
    end

    always_comb begin
        state_d       = state_q;
        j_d           = j_q;
        buf_d         = buf_q;
        rbuf_d        = rbuf_q;
        fg_d          = fg_q;
        wegt_d        = wegt_q;
        t_d           = t_q;
        acc_d         = acc_q;
        bus.readAddr  = '0;
        bus.writeAddr = '0;
        bus.writeOut  = '0;
        bus.writeEn   = 1'b0;
        bus.done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    j_d     = '0;
                    state_d = S_RD0;
                end
            end
            S_RD0: begin
                bus.readAddr = bus.bufAddr + ADDR_W'(j_q);
                state_d      = S_RD1;
            end
            // Each RDn latches the word requested by the previous state.
            S_RD1: begin
                buf_d        = bus.readIn[15:0];
                bus.readAddr = bus.rbufAddr + ADDR_W'(j_q);
                state_d      = S_RD2;
            end
            S_RD2: begin
                rbuf_d       = bus.readIn[15:0];
                bus.readAddr = bus.fgSumAddr + ADDR_W'(j_q);
                state_d      = S_RD3;
            end
            S_RD3: begin
                fg_d         = bus.readIn[15:0];
                bus.readAddr = bus.wegtAddr + ADDR_W'(j_q);
                state_d      = S_RD4;
            end
            S_RD4: begin
                wegt_d  = bus.readIn[15:0];
                state_d = S_C1;
            end
            S_C1: begin
                t_d     = c1_t;
                state_d = S_C2;
            end
            S_C2: begin
                acc_d = c2_acc;
                if (j_q == JW'(M - 1)) begin
                    state_d = S_WRITE;
                end else begin
                    j_d     = j_q + JW'(1);
                    state_d = S_RD0;
                end
            end
            S_WRITE: begin
                bus.writeAddr = bus.L_tdist;
                bus.writeOut  = DATA_W'(acc_q);
                bus.writeEn   = 1'b1;
                state_d       = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            j_q     <= '0;
            buf_q   <= '0;
            rbuf_q  <= '0;
            fg_q    <= '0;
            wegt_q  <= '0;
            t_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            buf_q   <= buf_d;
            rbuf_q  <= rbuf_d;
            fg_q    <= fg_d;
            wegt_q  <= wegt_d;
            t_q     <= t_d;
            acc_q   <= acc_d;
        end
    end

    assign dbg_state_o = state_q;

    // Only the low halfword of a scratch word carries data.
    logic unused_hi;
    assign unused_hi = ^bus.readIn[DATA_W-1:16];
endmodule

// File: doc/lsp_get_tdist.md
Name: lsp_get_tdist

Overview:
- Computes the weighted distance L_tdist for one MA-predictor mode of the LSP quantizer (G.729 Lsp_get_tdist).
- Reads four M-element Q-format arrays (wegt, buf, rbuf, fg_sum) from scratch memory and accumulates with ITU basic-op saturation.
- Writes the 32-bit result to a caller-given scratch address.
- Runs once per mode. The last-select stage that follows consumes the written L_tdist words.

Parameters:
- M, 10, number of LSP coefficients per vector
- ADDR_W, 11, scratch memory address width
- DATA_W, 32, scratch memory word width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- wegtAddr  in  ADDR_W  base address of wegt[0..M-1]
- bufAddr  in  ADDR_W  base address of buf[0..M-1]
- rbufAddr  in  ADDR_W  base address of rbuf[0..M-1]
- fgSumAddr  in  ADDR_W  base address of fg_sum[0..M-1]
- L_tdist  in  ADDR_W  address where the result word is written
- readIn  in  DATA_W  scratch read data, valid 1 cycle after readAddr
- readAddr  out  ADDR_W  scratch read address
- writeAddr  out  ADDR_W  scratch write address
- writeOut  out  DATA_W  scratch write data
- writeEn  out  1  scratch write strobe
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async): state=IDLE, j=0, accumulator=0. readAddr, writeAddr, writeOut, writeEn and done are all 0.
- Reset asserted mid-operation aborts immediately: no write, no done.
- Memory data is 16-bit signed in readIn[15:0]; bits [31:16] are ignored.
- Addresses used are base+j, modulo 2^ADDR_W.
- FSM states: IDLE, RD0, RD1, RD2, RD3, RD4, C1, C2, WRITE, DONE.
  - IDLE: on start=1, clear the accumulator, set j=0, go to RD0.
  - RD0: readAddr=bufAddr+j.
  - RD1: latch buf; readAddr=rbufAddr+j.
  - RD2: latch rbuf; readAddr=fgSumAddr+j.
  - RD3: latch fg_sum; readAddr=wegtAddr+j.
  - RD4: latch wegt.
  - C1: t = sub(buf, rbuf) (16-bit saturating). Then t = extract_h(L_shl(L_mult(t, fg_sum), 3)).
  - C2: t2 = extract_h(L_shl(L_mult(wegt, t), 4)). Then acc = L_add(acc, L_mult(t2, t)), saturating.
  - C2 transition: if j==M-1 go to WRITE; else j=j+1 and go to RD0.
  - WRITE: writeAddr=L_tdist, writeOut=acc, writeEn=1 for exactly this cycle.
  - DONE: done=1 for one cycle, then IDLE.
- Arithmetic rules:
  - L_mult(a,b) = 2ab. The case 0x8000*0x8000 returns 0x7FFFFFFF.
  - L_shl saturates to 0x7FFFFFFF / 0x80000000.
  - extract_h takes bits [31:16].
- Latency: start sampled at edge 0. Each element takes 7 cycles.
  - Element loop occupies cycles 1..7M.
  - writeEn is asserted in cycle 7M+1 (71 for M=10).
  - done is asserted in cycle 7M+2 (72).
- start while not in IDLE is ignored.
- start asserted in the DONE cycle is ignored. A new start is accepted in the IDLE cycle after done.
- Base addresses and L_tdist are sampled combinationally every cycle. The caller holds them stable from start until done.
- writeEn is never asserted outside WRITE. readAddr is 0 in IDLE, WRITE and DONE.

Test Plan:
- All arrays zero, L_tdist=0x100, start -> write 0x00000000 to 0x100 in cycle 71; done in cycle 72; exactly one writeEn pulse.
- Element 0 only: buf=0x0100, rbuf=0, fg_sum=0x4000, wegt=0x1000; others zero -> writeOut=0x00400000.
- Subtract saturation: buf[0]=0x7FFF, rbuf[0]=0x8000, fg_sum[0]=0x7FFF, wegt[0]=0x0800; others zero -> sub and L_shl saturate, writeOut=0x7FFE0002.
- Accumulator saturation: elements 0 and 1 both set to buf=0x1000, rbuf=0, fg_sum=0x7FFF, wegt=0x0800 -> writeOut=0x7FFFFFFF.
- Reset pulse at cycle 30, then new start with zero arrays -> no write before restart; one write of 0 at restart+71; done at restart+72.
- start pulsed at cycle 10 and again in the DONE cycle -> both ignored; exactly one done; readAddr order per element is buf, rbuf, fg_sum, wegt at base+j.
